dmem_dual_arbiter: RTL and testbench

- Arbitrates the single data-memory port between the two MEM-stage slots (inst1, inst2) of the dual-issue pipeline.
- Sits between the EX/MEM pipeline registers for both slots and the data RAM.
- Single-slot accesses pass straight through with no stall.
- Simultaneous accesses are serialised in program order (inst1 then inst2) over two cycles. During the first cycle, stall_mem freezes PC, IF/ID, ID/EX and both EX/MEM registers.

---
 rtl/dmem_dual_arbiter.sv | 107 ++++++++++
 tb/tb_dmem_dual_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_dual_arbiter.sv
// Shares the single data-RAM port between the two MEM-stage slots of the dual-issue pipeline.
// Optional store-to-load forwarding for same-address slot1-store/slot2-load pairs: DMEM_STORE_LOAD_FWD_EN.
module dmem_dual_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem1_rd,
  input  logic              mem1_wr,
  input  logic [ADDR_W-1:0] mem1_addr,
  input  logic [DATA_W-1:0] mem1_wdata,
  input  logic              mem2_rd,
  input  logic              mem2_wr,
  input  logic [ADDR_W-1:0] mem2_addr,
  input  logic [DATA_W-1:0] mem2_wdata,
  input  logic              flush_2,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_rd,
  output logic              dmem_wr,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              stall_mem,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] hold1;
  logic              req1, req2, conflict, fwd, serialise;

  assign req1     = mem1_rd | mem1_wr;
  assign req2     = mem2_rd | mem2_wr;
  assign conflict = req1 & req2 & ~flush_2;

`ifdef DMEM_STORE_LOAD_FWD_EN
  assign fwd = mem1_wr & mem2_rd & ~mem2_wr & (mem1_addr == mem2_addr);
`else
  assign fwd = 1'b0;
`endif

  assign serialise = (state == IDLE) & conflict & ~fwd & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      hold1        <= '0;
      conflict_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (serialise) begin
        hold1 <= dmem_rdata;
        if (conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    state_nxt  = IDLE;
    dmem_addr  = mem1_addr;
    dmem_wdata = mem1_wdata;
    dmem_rd    = 1'b0;
    dmem_wr    = 1'b0;
    rdata1     = dmem_rdata;
    rdata2     = dmem_rdata;
    stall_mem  = 1'b0;
    if (reset) begin
      rdata1 = '0;
      rdata2 = '0;
    end else begin
      case (state)
        IDLE: begin
          if (req1) begin
            // Slot 1 always goes first, so a store lands before any slot-2 access.
            dmem_wr = mem1_wr;
            dmem_rd = mem1_rd & ~mem1_wr;
            if (conflict && !fwd) begin
              stall_mem = 1'b1;
              state_nxt = SECOND;
            end
            if (conflict && fwd) rdata2 = mem1_wdata;
          end else if (req2 && !flush_2) begin
            dmem_addr  = mem2_addr;
            dmem_wdata = mem2_wdata;
            dmem_wr    = mem2_wr;
            dmem_rd    = mem2_rd & ~mem2_wr;
          end
        end
        SECOND: begin
          // Slot-2 inputs are still valid here because the pipeline was frozen.
          rdata1     = hold1;
          dmem_addr  = mem2_addr;
          dmem_wdata = mem2_wdata;
          if (!flush_2) begin
            dmem_wr = mem2_wr;
            dmem_rd = mem2_rd & ~mem2_wr;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_dual_arbiter.sv
// Directed bench for dmem_dual_arbiter with a behavioural RAM (combinational read, clocked write).
module tb_dmem_dual_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem1_rd, mem1_wr, mem2_rd, mem2_wr, flush_2;
  logic [7:0]  mem1_addr, mem2_addr;
  logic [31:0] mem1_wdata, mem2_wdata;
  logic [31:0] dmem_rdata;
  logic [7:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_rd, dmem_wr;
  logic [31:0] rdata1, rdata2;
  logic        stall_mem;
  logic [15:0] conflict_cnt;

  logic [31:0] ram [256];
  int          checks = 0;
  int          errors = 0;
  int          exp_cnt = 0;

  always #5 clk = ~clk;

  dmem_dual_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .mem1_rd(mem1_rd), .mem1_wr(mem1_wr), .mem1_addr(mem1_addr), .mem1_wdata(mem1_wdata),
    .mem2_rd(mem2_rd), .mem2_wr(mem2_wr), .mem2_addr(mem2_addr), .mem2_wdata(mem2_wdata),
    .flush_2(flush_2), .dmem_rdata(dmem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
    .rdata1(rdata1), .rdata2(rdata2), .stall_mem(stall_mem), .conflict_cnt(conflict_cnt)
  );

  assign dmem_rdata = ram[dmem_addr];
  always @(posedge clk) if (dmem_wr) ram[dmem_addr] <= dmem_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    mem1_rd = 0; mem1_wr = 0; mem2_rd = 0; mem2_wr = 0; flush_2 = 0;
    mem1_addr = 0; mem2_addr = 0; mem1_wdata = 0; mem2_wdata = 0;
  endtask

  task automatic load_pair();
    idle();
    mem1_rd = 1; mem1_addr = 8'h04;
    mem2_rd = 1; mem2_addr = 8'h08;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[8'h10] = 32'hDEADBEEF;
    ram[8'h04] = 32'h11;
    ram[8'h08] = 32'h22;
    ram[8'h30] = 32'h55;
    idle();
    reset = 1;
    mem1_rd = 1; mem1_addr = 8'h10;
    cyc();
    smp();
    chk("rst_stall", stall_mem, 0);
    chk("rst_rd", dmem_rd, 0);
    chk("rst_wr", dmem_wr, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_cnt", conflict_cnt, 0);
    cyc();
    reset = 0;

    // slot-1 load alone
    smp();
    chk("s1_rdata1", rdata1, 32'hDEADBEEF);
    chk("s1_stall", stall_mem, 0);
    chk("s1_rd", dmem_rd, 1);
    chk("s1_cnt", conflict_cnt, 0);
    cyc();

    // two loads serialised
    load_pair();
    smp();
    chk("ll0_stall", stall_mem, 1);
    chk("ll0_addr", dmem_addr, 8'h04);
    cyc();
    exp_cnt++;
    smp();
    chk("ll1_stall", stall_mem, 0);
    chk("ll1_addr", dmem_addr, 8'h08);
    chk("ll1_rdata1", rdata1, 32'h11);
    chk("ll1_rdata2", rdata2, 32'h22);
    chk("ll1_cnt", conflict_cnt, exp_cnt);
    cyc();
    idle();

    // slot-1 store, slot-2 load of the same word
    mem1_wr = 1; mem1_addr = 8'h20; mem1_wdata = 32'hA5;
    mem2_rd = 1; mem2_addr = 8'h20;
    smp();
    chk("sl0_wr", dmem_wr, 1);
`ifdef DMEM_STORE_LOAD_FWD_EN
    chk("sl0_stall", stall_mem, 0);
    chk("sl0_rdata2", rdata2, 32'hA5);
    cyc();
    idle();
    chk("sl_ram", ram[8'h20], 32'hA5);
    chk("sl_cnt", conflict_cnt, exp_cnt);
`else
    chk("sl0_stall", stall_mem, 1);
    cyc();
    exp_cnt++;
    smp();
    chk("sl1_stall", stall_mem, 0);
    chk("sl1_rd", dmem_rd, 1);
    chk("sl1_rdata2", rdata2, 32'hA5);
    chk("sl1_cnt", conflict_cnt, exp_cnt);
    cyc();
    idle();
`endif

    // conflict whose slot-2 store is flushed in the second cycle
    mem1_rd = 1; mem1_addr = 8'h04;
    mem2_wr = 1; mem2_addr = 8'h30; mem2_wdata = 32'h77;
    smp();
    chk("fl0_stall", stall_mem, 1);
    cyc();
    exp_cnt++;
    flush_2 = 1;
    smp();
    chk("fl1_wr", dmem_wr, 0);
    chk("fl1_stall", stall_mem, 0);
    chk("fl1_rdata1", rdata1, 32'h11);
    cyc();
    idle();
    chk("fl_ram", ram[8'h30], 32'h55);
    // back in IDLE: a lone slot-1 load must own the port
    mem1_rd = 1; mem1_addr = 8'h10; mem2_addr = 8'h30;
    smp();
    chk("fl2_addr", dmem_addr, 8'h10);
    chk("fl2_rdata1", rdata1, 32'hDEADBEEF);
    chk("fl2_cnt", conflict_cnt, exp_cnt);
    cyc();
    idle();

    // flush_2 in IDLE turns a conflict into a lone slot-1 access
    load_pair();
    flush_2 = 1;
    smp();
    chk("fi_stall", stall_mem, 0);
    chk("fi_addr", dmem_addr, 8'h04);
    cyc();
    idle();
    smp();
    chk("fi_cnt", conflict_cnt, exp_cnt);

    // slot-2 alone, rd and wr both set: the store wins
    mem2_rd = 1; mem2_wr = 1; mem2_addr = 8'h40; mem2_wdata = 32'h44;
    smp();
    chk("s2_rd", dmem_rd, 0);
    chk("s2_wr", dmem_wr, 1);
    chk("s2_addr", dmem_addr, 8'h40);
    chk("s2_stall", stall_mem, 0);
    cyc();
    idle();
    chk("s2_ram", ram[8'h40], 32'h44);

    // reset arriving while in SECOND
    load_pair();
    cyc();
    reset = 1;
    smp();
    chk("rs_stall", stall_mem, 0);
    chk("rs_rd", dmem_rd, 0);
    chk("rs_rdata1", rdata1, 0);
    cyc();
    reset = 0;
    exp_cnt = 0;
    smp();
    chk("rs_idle_stall", stall_mem, 1);
    chk("rs_cnt", conflict_cnt, exp_cnt);
    cyc();
    exp_cnt++;
    smp();
    chk("rs2_rdata1", rdata1, 32'h11);
    chk("rs2_cnt", conflict_cnt, exp_cnt);
    cyc();
    idle();

    // saturation: preload near the top, then keep conflicting
    force dut.conflict_cnt = 16'hFFFC;
    #1;
    release dut.conflict_cnt;
    load_pair();
    for (int i = 0; i < 6; i++) cyc();
    smp();
    chk("sat_reach", conflict_cnt, 16'hFFFF);
    cyc();
    for (int i = 0; i < 6; i++) cyc();
    smp();
    chk("sat_hold", conflict_cnt, 16'hFFFF);
    cyc();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
